// File: rtl/rng_arbiter.sv
// rng_arbiter: round-robin arbiter in front of one shared xorshift32 generator.
// After reset or reseed the generator is seeded from seed_ID, stepped 16 times
// (warm-up), then each granted requester receives the current word and the
// generator advances. Optional grant counter enabled by `define RNG_ARB_CNT_EN.
module rng_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         seed_ID,
  input  logic               seed_load,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [31:0]        rand_out,
  output logic               rand_valid,
  output logic [1:0]         phase
`ifdef RNG_ARB_CNT_EN
  , output logic [15:0]      grant_cnt
`endif
);
  localparam int PW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {SEED = 2'b00, WARMUP = 2'b01, RUN = 2'b10} phase_t;

  phase_t             state, state_nxt;
  logic [31:0]        x;
  logic [3:0]         wcnt;
  logic [PW-1:0]      ptr;
  logic               hit;
  logic               issue;
  logic [PW-1:0]      win;
  logic [PW-1:0]      cand;
  logic [NUM_REQ-1:0] win_oh;

  function automatic logic [31:0] xs_step(input logic [31:0] v);
    logic [31:0] t;
    t = v ^ (v << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  // Round-robin pick: scan offsets from the far end down so the nearest
  // requester after ptr is the last one written and therefore wins.
  always_comb begin
    hit    = 1'b0;
    win    = ptr;
    cand   = '0;
    win_oh = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = PW'((int'(ptr) + i) % NUM_REQ);
      if (req[cand]) begin
        hit = 1'b1;
        win = cand;
      end
    end
    if (hit) win_oh[win] = 1'b1;
  end

  // A grant is issued only in RUN, and a reseed request suppresses it.
  assign issue = (state == RUN) && !seed_load && hit;

  // Phase register.
  always_ff @(posedge clk) begin
    if (reset) state <= SEED;
    else       state <= state_nxt;
  end

  // Phase sequencing: SEED is a single edge, warm-up is exactly 16 edges.
  always_comb begin
    state_nxt = state;
    case (state)
      SEED:    state_nxt = WARMUP;
      WARMUP:  if (seed_load) state_nxt = SEED;
               else if (wcnt == 4'd15) state_nxt = RUN;
      RUN:     if (seed_load) state_nxt = SEED;
      default: state_nxt = SEED;
    endcase
  end

  // Generator state, warm-up counter, round-robin pointer and grant outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      x        <= '0;
      wcnt     <= '0;
      ptr      <= PW'(NUM_REQ - 1);
      gnt      <= '0;
      rand_out <= '0;
    end else begin
      gnt <= '0;
      case (state)
        SEED: begin
          x    <= {~seed_ID, seed_ID, 16'h9E37};
          wcnt <= '0;
        end
        WARMUP: begin
          if (!seed_load) begin
            x    <= xs_step(x);
            wcnt <= wcnt + 4'd1;
          end
        end
        RUN: begin
          if (issue) begin
            gnt      <= win_oh;
            rand_out <= x;
            x        <= xs_step(x);
            ptr      <= win;
          end
        end
        default: ;
      endcase
    end
  end

  assign rand_valid = |gnt;
  assign phase      = state;

`ifdef RNG_ARB_CNT_EN
  // Grants issued since the last SEED edge; wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (reset || state == SEED) grant_cnt <= '0;
    else if (issue)             grant_cnt <= grant_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_rng_arbiter.sv
// Bench for rng_arbiter: directed vectors, a cycle-level reference model
// compared every cycle, and literal expectations pinning the model.
module tb_rng_arbiter;
  localparam int NUM_REQ = 4;

  logic               clk;
  logic               reset;
  logic [7:0]         seed_ID;
  logic               seed_load;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [31:0]        rand_out;
  logic               rand_valid;
  logic [1:0]         phase;
`ifdef RNG_ARB_CNT_EN
  logic [15:0]        grant_cnt;
`endif

  rng_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk(clk), .reset(reset), .seed_ID(seed_ID), .seed_load(seed_load),
    .req(req), .gnt(gnt), .rand_out(rand_out), .rand_valid(rand_valid),
    .phase(phase)
`ifdef RNG_ARB_CNT_EN
    , .grant_cnt(grant_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;
  bit started = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_xs(input logic [31:0] v);
    v = v ^ (v << 13);
    v = v ^ (v >> 17);
    v = v ^ (v << 5);
    return v;
  endfunction

  function automatic logic [31:0] ref_seed(input logic [7:0] s);
    return {~s, s, 16'h9E37};
  endfunction

  // Reference model: phase tracked as 0/1/2 with a remaining warm-up count,
  // arbitration as a plain rotating scan over integer indices.
  int                 m_ph;
  int                 m_wleft;
  int                 m_ptr;
  int                 m_cnt;
  logic [31:0]        m_x;
  logic [31:0]        e_rand;
  logic [NUM_REQ-1:0] e_gnt;

  always @(posedge clk) begin
    if (reset) begin
      m_ph = 0; m_wleft = 0; m_ptr = NUM_REQ - 1; m_cnt = 0;
      m_x = 0; e_rand = 0; e_gnt = 0;
    end else if (m_ph == 0) begin
      m_x = ref_seed(seed_ID); m_wleft = 16; m_ph = 1; e_gnt = 0; m_cnt = 0;
    end else if (seed_load) begin
      m_ph = 0; e_gnt = 0;
    end else if (m_ph == 1) begin
      m_x = ref_xs(m_x); m_wleft--; e_gnt = 0;
      if (m_wleft == 0) m_ph = 2;
    end else begin
      e_gnt = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
        int c;
        c = (m_ptr + k) % NUM_REQ;
        if (req[c] && e_gnt == 0) begin
          e_gnt[c] = 1'b1; e_rand = m_x; m_x = ref_xs(m_x); m_ptr = c; m_cnt++;
        end
      end
    end
  end

  // Per-cycle compare, sampled on the falling edge.
  always @(negedge clk) begin
    if (started) begin
      chk("phase", 32'(phase), 32'(m_ph));
      chk("gnt", 32'(gnt), 32'(e_gnt));
      chk("rand_valid", 32'(rand_valid), 32'(|e_gnt));
      chk("rand_out", rand_out, e_rand);
`ifdef RNG_ARB_CNT_EN
      chk("grant_cnt", 32'(grant_cnt), 32'(m_cnt & 16'hFFFF));
`endif
    end
  end

  task automatic do_reset(input logic [7:0] s, input logic [NUM_REQ-1:0] r);
    @(negedge clk);
    reset = 1'b1; seed_ID = s; req = r; seed_load = 1'b0;
    @(negedge clk);
    started = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [31:0] prev;
  logic [31:0] words [4];
  int          vcount;

  initial begin
    reset = 1'b1; seed_ID = 8'h00; seed_load = 1'b0; req = '0;

    // Pin model helpers against hand-computed values.
    chk("xs_of_1", ref_xs(32'h1), 32'h0004_2021);
    chk("seed_00", ref_seed(8'h00), 32'hFF00_9E37);

    // Reset state and phase sequence with no requests.
    do_reset(8'h00, 4'b0000);
    chk("reset_gnt", 32'(gnt), 32'h0);
    chk("reset_rand", rand_out, 32'h0);
    chk("reset_phase", 32'(phase), 32'h0);
    @(negedge clk);
    chk("ph_after_e1", 32'(phase), 32'h1);
    chk("x_after_seed", m_x, 32'hFF00_9E37);
    repeat (15) @(negedge clk);
    chk("ph_after_e16", 32'(phase), 32'h1);
    @(negedge clk);
    chk("ph_after_e17", 32'(phase), 32'h2);
    repeat (3) @(negedge clk);
    chk("idle_gnt", 32'(gnt), 32'h0);

    // All requesting from reset: rotation starts at requester 0.
    do_reset(8'h00, 4'b1111);
    repeat (17) @(negedge clk);
    chk("no_gnt_e17", 32'(gnt), 32'h0);
    @(negedge clk); chk("rr_1", 32'(gnt), 32'b0001);
    @(negedge clk); chk("rr_2", 32'(gnt), 32'b0010);
    @(negedge clk); chk("rr_3", 32'(gnt), 32'b0100);
    @(negedge clk); chk("rr_4", 32'(gnt), 32'b1000);
    @(negedge clk); chk("rr_5", 32'(gnt), 32'b0001);

    // Single held requester: grant every cycle, fresh word each time.
    prev = rand_out;
    req = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("single_gnt", 32'(gnt), 32'b0100);
      chk("single_new_word", 32'(rand_out != prev), 32'h1);
      prev = rand_out;
    end
    req = 4'b1111;
    @(negedge clk); chk("ptr_is_2", 32'(gnt), 32'b1000);

    // Move ptr to 1, then alternate between requesters 3 and 1.
    req = 4'b0010;
    @(negedge clk); chk("set_ptr1", 32'(gnt), 32'b0010);
    req = 4'b1010;
    @(negedge clk); chk("alt_1", 32'(gnt), 32'b1000);
    @(negedge clk); chk("alt_2", 32'(gnt), 32'b0010);
    @(negedge clk); chk("alt_3", 32'(gnt), 32'b1000);
    req = 4'b0000;
    prev = rand_out;
    repeat (2) begin
      @(negedge clk);
      chk("idle_valid", 32'(rand_valid), 32'h0);
      chk("idle_hold", rand_out, prev);
    end
    req = 4'b0001;
    @(negedge clk); chk("after_idle", 32'(gnt), 32'b0001);

    // Reseed mid-run: grant suppressed, 17 quiet cycles, ptr preserved.
    req = 4'b1111;
    @(negedge clk); chk("pre_pulse_1", 32'(gnt), 32'b0010);
    @(negedge clk); chk("pre_pulse_2", 32'(gnt), 32'b0100);
    seed_load = 1'b1; seed_ID = 8'h5A;
    @(negedge clk);
    chk("pulse_gnt", 32'(gnt), 32'h0);
    chk("pulse_phase", 32'(phase), 32'h0);
    seed_load = 1'b0;
    vcount = 0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (i == 0) chk("x_seed_5a", m_x, 32'hA55A_9E37);
      if (rand_valid) vcount++;
    end
    chk("quiet_cycles", 32'(vcount), 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) chk("reseed_first", 32'(gnt), 32'b1000);
      words[i] = rand_out;
    end

    // Fresh reset with the same seed must give the same word sequence.
    do_reset(8'h5A, 4'b1111);
    repeat (17) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) chk("fresh_first", 32'(gnt), 32'b0001);
      chk("fresh_word", rand_out, words[i]);
    end

`ifdef RNG_ARB_CNT_EN
    // Counter wrap with one held requester, then clear through SEED.
    do_reset(8'h00, 4'b0001);
    repeat (17) @(negedge clk);
    repeat (70000) @(negedge clk);
    chk("cnt_wrap", 32'(grant_cnt), 32'd4464);
    seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    @(negedge clk);
    chk("cnt_clear", 32'(grant_cnt), 32'h0);
`endif

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rng_arbiter.md
# rng_arbiter

Round-robin arbiter that shares one seeded xorshift32 random-number generator among NUM_REQ site-evolution workers. It sits beside the Schedule sequencer and uses the same 8-bit seed_ID. On reset or reseed it seeds the generator, runs a fixed warm-up, then hands out one 32-bit random word per cycle to exactly one requester. Runs are reproducible for a given seed_ID and request pattern.

## Interface
- NUM_REQ, 4: number of requesters, legal range 2..8.
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- seed_ID  in  8  seed value; sampled only in SEED phase.
- seed_load  in  1  request reseed; level, sampled each edge.
- req  in  NUM_REQ  per-requester request, level-sensitive.
- gnt  out  NUM_REQ  registered grant, one-hot or zero.
- rand_out  out  32  random word for the granted requester; valid with rand_valid.
- rand_valid  out  1  equals |gnt.
- phase  out  2  controller phase: SEED=2'b00, WARMUP=2'b01, RUN=2'b10.

## Operation
- Generator state x, 32 bits. Step: x ^= x<<13; x ^= x>>17; x ^= x<<5, applied in that order on the same value.
- Seed value: x = {~seed_ID, seed_ID, 16'h9E37}. It is never zero, so x never becomes all-zero.
- SEED: load x from the seed value, clear wcnt (4 bits), go to WARMUP. No grants in this phase.
- WARMUP: step x and increment wcnt on every edge. On the edge where wcnt==15, step x and go to RUN. This gives exactly 16 steps. No grants in this phase.
- RUN, on each edge:
  - If any req bit is set, grant the first set bit searching upward from ptr+1 modulo NUM_REQ.
  - Set gnt to that one-hot bit and rand_out to the current x. Step x and set ptr to the granted index.
  - If no req bit is set, gnt=0, rand_valid=0, and x and ptr are held. rand_out holds its last value.
- A requester that keeps req high stays eligible every cycle. A single requester with req held high gets a grant every cycle.
- seed_load=1 in WARMUP or RUN: next phase is SEED. No grant on that edge, gnt=0, and ptr is kept. seed_load in SEED is ignored.
- reset overrides seed_load and req.

## Timing
- Reset values (reset high at an edge): phase=SEED, gnt=0, rand_valid=0, rand_out=0, x=0, wcnt=0, ptr=NUM_REQ-1, so requester 0 wins first.
- First edge with reset low: SEED→WARMUP.
- Edges 2..17 after reset release: warm-up. phase reads RUN after edge 17.
- Edge 18: first possible grant. gnt is visible in the cycle after edge 18.
- Grant latency: 1 cycle. A req sampled at edge N produces gnt/rand_out after edge N.
- Throughput: one grant per cycle in RUN.
- Each word is used exactly once. Consecutive grants carry successive xorshift32 states.
- Reseed via seed_load: 1 SEED edge plus 16 WARMUP edges, then RUN.
- req during SEED or WARMUP is ignored, not queued.

## Configuration
- RNG_ARB_CNT_EN defined: adds output port grant_cnt (out, 16 bits).
  - Counts grants since the last SEED phase.
  - Cleared by reset and in SEED. Increments on every edge that issues a grant.
  - Wraps from 16'hFFFF to 16'h0000.
- RNG_ARB_CNT_EN undefined: port and counter are absent. Behaviour is otherwise identical.

## Test plan
- Reset, seed_ID=8'h00, req=4'b0000: phase sequence is SEED(1 cycle) → WARMUP(16 cycles) → RUN. gnt stays 0, and x after SEED = 32'hFF009E37.
- seed_ID=8'h00, req=4'b1111 held from reset: first gnt=4'b0001 after edge 18, then 0010, 0100, 1000, 0001. rand_out matches the golden xorshift32 successors 16, 17, 18… of 32'hFF009E37.
- req=4'b0100 only, held for 5 cycles in RUN: gnt=4'b0100 for 5 consecutive cycles, each carrying a distinct successive word. ptr=2 afterwards.
- req=4'b1010 with ptr=1: grants alternate 1000, 0010, 1000. Then req drops to 0: gnt=0, rand_valid=0, and the next grant uses the held x.
- seed_load=1 pulsed mid-RUN with req=4'b1111, then seed_ID=8'h5A: no grant on the pulse edge, then 17 cycles without grants. Afterwards the sequence equals a fresh-reset run with seed_ID=8'h5A, with ptr preserved.
- RNG_ARB_CNT_EN: 70000 grants from one held requester → grant_cnt = 70000 mod 65536 = 4464. It returns to 0 on seed_load.
